// File: rtl/scripted_player_if.sv
// rtl/scripted_player_if.sv - board-side move handshake between scripted_player and the board
interface scripted_player_if #(
    parameter int IDX_W = 4
) ();
    logic             turn;
    logic             move_ack;
    logic             move_nak;
    logic [IDX_W-1:0] update_loc;
    logic             submit;
    logic             game_reset;
    logic             drive_en;

    modport master (
        input  turn, move_ack, move_nak,
        output update_loc, submit, game_reset, drive_en
    );

    modport slave (
        output turn, move_ack, move_nak,
        input  update_loc, submit, game_reset, drive_en
    );
endinterface

// File: rtl/scripted_player.sv
// rtl/scripted_player.sv - scripted opponent replaying stored move scripts; SCRIPTED_PLAYER_RETRY_EN skips naked moves
module scripted_player #(
    parameter int BOARD_DIM = 3,
    parameter int IDX_W     = 4,
    parameter int MAX_MOVES = 5,
    parameter int NUM_GAMES = 6,
    localparam int CELLS    = BOARD_DIM * BOARD_DIM,
    localparam int SLOT_W   = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1,
    localparam int GAME_W   = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [GAME_W-1:0]   game_sel,
    input  logic                cfg_we,
    input  logic [GAME_W-1:0]   cfg_game,
    input  logic [SLOT_W-1:0]   cfg_slot,
    input  logic [IDX_W-1:0]    cfg_loc,
    input  logic                cfg_last,
    scripted_player_if.master   brd,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [SLOT_W:0]     move_count
);

    generate
        if ((1 << IDX_W) < CELLS) begin : g_bad_idx_w
            $error("IDX_W cannot address every board cell");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, CLR, WAIT_TURN, SUBMIT, WAIT_AI, DONE, ERROR} state_t;

    state_t              state, next_state;
    logic [GAME_W-1:0]   game;
    logic [SLOT_W-1:0]   slot;
    logic                valid_mem [NUM_GAMES][MAX_MOVES];
    logic                last_mem  [NUM_GAMES][MAX_MOVES];
    logic [IDX_W-1:0]    loc_mem   [NUM_GAMES][MAX_MOVES];
    logic                cur_valid, cur_last, at_final, idle_like, cfg_ok;
    logic [IDX_W-1:0]    cur_loc;
    logic                load_game, count_up, slot_up;

    assign cur_valid = valid_mem[game][slot];
    assign cur_last  = last_mem[game][slot];
    assign cur_loc   = loc_mem[game][slot];
    assign at_final  = cur_last || (int'(slot) == MAX_MOVES - 1);
    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);
    assign cfg_ok    = cfg_we && idle_like && (int'(cfg_game) < NUM_GAMES) && (int'(cfg_slot) < MAX_MOVES);

    // start pre-empts every state, so a busy game is aborted in the same cycle
    always_comb begin
        next_state = state;
        load_game  = 1'b0;
        count_up   = 1'b0;
        slot_up    = 1'b0;
        if (start) begin
            if (int'(game_sel) >= NUM_GAMES) begin
                next_state = ERROR;
            end else begin
                next_state = CLR;
                load_game  = 1'b1;
            end
        end else begin
            case (state)
                CLR:       next_state = WAIT_TURN;
                WAIT_TURN: begin
                    if (!cur_valid)     next_state = DONE;
                    else if (!brd.turn) next_state = SUBMIT;
                end
                SUBMIT: begin
                    if (brd.move_nak) begin
`ifdef SCRIPTED_PLAYER_RETRY_EN
                        if (at_final) begin
                            next_state = DONE;
                        end else begin
                            slot_up    = 1'b1;
                            next_state = WAIT_TURN;
                        end
`else
                        next_state = ERROR;
`endif
                    end else if (brd.move_ack) begin
                        count_up = 1'b1;
                        if (at_final) begin
                            next_state = DONE;
                        end else begin
                            slot_up    = 1'b1;
                            next_state = WAIT_AI;
                        end
                    end else if (brd.turn) begin
                        next_state = WAIT_TURN;
                    end
                end
                WAIT_AI:   if (brd.turn) next_state = WAIT_TURN;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            game           <= '0;
            slot           <= '0;
            move_count     <= '0;
            brd.submit     <= 1'b0;
            brd.drive_en   <= 1'b0;
            brd.game_reset <= 1'b0;
            brd.update_loc <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= next_state;
            brd.submit     <= (next_state == SUBMIT);
            brd.drive_en   <= (next_state == SUBMIT);
            brd.update_loc <= (next_state == SUBMIT) ? cur_loc : '0;
            brd.game_reset <= (next_state == CLR);
            busy           <= !((next_state == IDLE) || (next_state == DONE) || (next_state == ERROR));
            done           <= (next_state == DONE);
            error          <= (next_state == ERROR);
            if (start) begin
                slot       <= '0;
                move_count <= '0;
                if (load_game) game <= game_sel;
            end else begin
                if (slot_up) slot <= slot + 1'b1;
                if (count_up && (int'(move_count) < MAX_MOVES)) move_count <= move_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < NUM_GAMES; g++)
                for (int s = 0; s < MAX_MOVES; s++)
                    valid_mem[g][s] <= 1'b0;
        end else if (cfg_ok) begin
            valid_mem[cfg_game][cfg_slot] <= 1'b1;
        end
    end

    // script payload needs no reset; valid gates every read
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            last_mem[cfg_game][cfg_slot] <= cfg_last;
            loc_mem[cfg_game][cfg_slot]  <= cfg_loc;
        end
    end

endmodule

// File: tb/tb_scripted_player.sv
// tb/tb_scripted_player.sv - directed self-checking bench for scripted_player
module tb_scripted_player;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] game_sel = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_game = '0;
    logic [2:0] cfg_slot = '0;
    logic [3:0] cfg_loc = '0;
    logic       cfg_last = 1'b0;
    logic       busy, done, error;
    logic [3:0] move_count;

    int checks = 0;
    int failures = 0;
    int gr_count = 0;
    int gr_mark;

    scripted_player_if #(.IDX_W(4)) brd ();

    scripted_player #(.BOARD_DIM(3), .IDX_W(4), .MAX_MOVES(5), .NUM_GAMES(6)) dut (
        .clk(clk), .rst(rst), .start(start), .game_sel(game_sel),
        .cfg_we(cfg_we), .cfg_game(cfg_game), .cfg_slot(cfg_slot),
        .cfg_loc(cfg_loc), .cfg_last(cfg_last), .brd(brd),
        .busy(busy), .done(done), .error(error), .move_count(move_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (brd.game_reset) gr_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic load(input int g, input int s, input int loc, input logic last);
        cfg_we   = 1'b1;
        cfg_game = 3'(g);
        cfg_slot = 3'(s);
        cfg_loc  = 4'(loc);
        cfg_last = last;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic kick(input int g);
        start    = 1'b1;
        game_sel = 3'(g);
        tick();
        start    = 1'b0;
    endtask

    int script1 [5] = '{4, 3, 1, 8, 6};
    int script0 [5] = '{0, 1, 2, 3, 5};

    initial begin
        brd.turn = 1'b1;
        brd.move_ack = 1'b0;
        brd.move_nak = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_submit", brd.submit, 0);
        check("rst_drive_en", brd.drive_en, 0);
        check("rst_game_reset", brd.game_reset, 0);
        check("rst_update_loc", brd.update_loc, 0);
        check("rst_flags", {busy, done, error}, 0);
        check("rst_count", move_count, 0);

        // full five-move script with turn toggling
        for (int i = 0; i < 5; i++) load(1, i, script1[i], i == 4);
        gr_mark = gr_count;
        kick(1);
        check("t1_game_reset", brd.game_reset, 1);
        check("t1_busy", busy, 1);
        tick();
        check("t1_reset_pulse_end", brd.game_reset, 0);
        for (int i = 0; i < 5; i++) begin
            brd.turn = 1'b0;
            tick();
            check("t1_submit", brd.submit, 1);
            check("t1_drive_en", brd.drive_en, 1);
            check("t1_loc", brd.update_loc, 32'(script1[i]));
            brd.move_ack = 1'b1;
            tick();
            brd.move_ack = 1'b0;
            check("t1_submit_drop", brd.submit, 0);
            check("t1_count", move_count, 32'(i + 1));
            brd.turn = 1'b1;
            tick();
        end
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_reset_pulses", 32'(gr_count - gr_mark), 1);

        // turn already 0 at start; no double submit while turn stays 0
        load(2, 0, 2, 1'b0);
        load(2, 1, 0, 1'b1);
        brd.turn = 1'b0;
        kick(2);
        check("t2_game_reset", brd.game_reset, 1);
        tick();
        check("t2_no_submit_yet", brd.submit, 0);
        tick();
        check("t2_submit", brd.submit, 1);
        check("t2_loc0", brd.update_loc, 2);
        brd.move_ack = 1'b1;
        tick();
        brd.move_ack = 1'b0;
        check("t2_count1", move_count, 1);
        tick(); tick();
        check("t2_hold_no_submit", brd.submit, 0);
        check("t2_busy", busy, 1);
        brd.turn = 1'b1;
        tick();
        brd.turn = 1'b0;
        tick();
        check("t2_submit2", brd.submit, 1);
        check("t2_loc1", brd.update_loc, 0);
        brd.move_ack = 1'b1;
        tick();
        brd.move_ack = 1'b0;
        check("t2_done", done, 1);
        check("t2_count2", move_count, 2);

        // out-of-range game selection
        brd.turn = 1'b1;
        kick(6);
        check("t3_error", error, 1);
        check("t3_game_reset", brd.game_reset, 0);
        check("t3_busy", busy, 0);
        check("t3_done", done, 0);

        // nak on the second move
        kick(1);
        tick();
        brd.turn = 1'b0;
        tick();
        check("t4_loc0", brd.update_loc, 4);
        brd.move_ack = 1'b1;
        tick();
        brd.move_ack = 1'b0;
        brd.turn = 1'b1;
        tick();
        brd.turn = 1'b0;
        tick();
        check("t4_loc1", brd.update_loc, 3);
        brd.move_nak = 1'b1;
        tick();
        brd.move_nak = 1'b0;
        check("t4_count", move_count, 1);
`ifdef SCRIPTED_PLAYER_RETRY_EN
        check("t4_no_error", error, 0);
        tick();
        check("t4_retry_submit", brd.submit, 1);
        check("t4_retry_loc", brd.update_loc, 1);
`else
        check("t4_error", error, 1);
        check("t4_submit_drop", brd.submit, 0);
        check("t4_busy", busy, 0);
`endif

        // withdrawal, resubmit, then abort mid-game
        brd.turn = 1'b1;
        kick(1);
        tick();
        brd.turn = 1'b0;
        tick();
        check("t5_submit", brd.submit, 1);
        check("t5_loc", brd.update_loc, 4);
        brd.turn = 1'b1;
        tick();
        check("t5_withdraw", brd.submit, 0);
        check("t5_withdraw_drive", brd.drive_en, 0);
        check("t5_busy", busy, 1);
        brd.turn = 1'b0;
        tick();
        check("t5_resubmit", brd.submit, 1);
        check("t5_resubmit_loc", brd.update_loc, 4);
        brd.move_ack = 1'b1;
        tick();
        brd.move_ack = 1'b0;
        check("t5_count1", move_count, 1);
        brd.turn = 1'b1;
        kick(1);
        check("t5_abort_reset", brd.game_reset, 1);
        check("t5_abort_count", move_count, 0);
        check("t5_abort_submit", brd.submit, 0);
        tick();

        // config write while busy is dropped; reset mid-submit
        load(1, 0, 7, 1'b0);
        brd.turn = 1'b0;
        tick();
        check("t6_loc_unchanged", brd.update_loc, 4);
        check("t6_submit", brd.submit, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_outputs", {brd.submit, brd.drive_en, brd.game_reset, busy, done, error}, 0);
        check("t6_rst_loc", brd.update_loc, 0);
        kick(1);
        tick(); tick();
        check("t6_empty_done", done, 1);
        check("t6_empty_count", move_count, 0);

        // script filling every slot without a last marker ends at the final slot
        for (int i = 0; i < 5; i++) load(0, i, script0[i], 1'b0);
        brd.turn = 1'b1;
        kick(0);
        tick();
        for (int i = 0; i < 5; i++) begin
            brd.turn = 1'b0;
            tick();
            check("t7_loc", brd.update_loc, 32'(script0[i]));
            brd.move_ack = 1'b1;
            tick();
            brd.move_ack = 1'b0;
            brd.turn = 1'b1;
            tick();
        end
        check("t7_done", done, 1);
        check("t7_count", move_count, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
